// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants, immediate-format enum and the ID/EX payload struct.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
  } ex_pkt_t;

  function automatic imm_type_t imm_type(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational sign-extended immediate generator for RV32I formats.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type(instr[6:0]))
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, flush and optional
// writeback bypass of register-file read data (macro ID_WB_BYPASS_EN).
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_d,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  output logic        ready_d,
  output logic [4:0]  a1,
  output logic [4:0]  a2,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ready_e,
  input  logic        flush_e,
  output logic        valid_e,
  output logic [31:0] pc_e,
  output logic [31:0] rs1_data_e,
  output logic [31:0] rs2_data_e,
  output logic [31:0] imm_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic [6:0]  opcode_e,
  output logic [2:0]  funct3_e,
  output logic        funct7b5_e
);

  ex_pkt_t     pkt_q, pkt_d;
  logic        vld_q;
  logic [31:0] imm;
  logic [31:0] src1, src2;
  logic        load_use, adv;

  imm_gen u_imm_gen (.instr(instr_d), .imm(imm));

  assign a1 = instr_d[19:15];
  assign a2 = instr_d[24:20];

`ifdef ID_WB_BYPASS_EN
  // Same-cycle writeback would otherwise be missed by the register-file read.
  assign src1 = (wb_we && wb_rd != 5'd0 && wb_rd == a1) ? wb_data : rd1;
  assign src2 = (wb_we && wb_rd != 5'd0 && wb_rd == a2) ? wb_data : rd2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
  assign src1 = rd1;
  assign src2 = rd2;
`endif

  // Format-agnostic match: a spurious stall is cheaper than decoding rs usage.
  assign load_use = vld_q && pkt_q.opcode == OP_LOAD && pkt_q.rd != 5'd0 &&
                    valid_d && (pkt_q.rd == a1 || pkt_q.rd == a2);
  assign adv      = !vld_q || ready_e;
  assign ready_d  = flush_e || (adv && !load_use);

  always_comb begin
    pkt_d          = '0;
    pkt_d.pc       = pc_d;
    pkt_d.rs1_data = (a1 == 5'd0) ? 32'd0 : src1;
    pkt_d.rs2_data = (a2 == 5'd0) ? 32'd0 : src2;
    pkt_d.imm      = imm;
    pkt_d.rs1      = instr_d[19:15];
    pkt_d.rs2      = instr_d[24:20];
    pkt_d.rd       = instr_d[11:7];
    pkt_d.opcode   = instr_d[6:0];
    pkt_d.funct3   = instr_d[14:12];
    pkt_d.funct7b5 = instr_d[30];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pkt_q <= '0;
    end else if (flush_e) begin
      vld_q <= 1'b0;
    end else if (load_use && ready_e) begin
      vld_q <= 1'b0;
    end else if (adv) begin
      vld_q <= valid_d;
      pkt_q <= pkt_d;
    end
  end

  assign valid_e    = vld_q;
  assign pc_e       = pkt_q.pc;
  assign rs1_data_e = pkt_q.rs1_data;
  assign rs2_data_e = pkt_q.rs2_data;
  assign imm_e      = pkt_q.imm;
  assign rs1_e      = pkt_q.rs1;
  assign rs2_e      = pkt_q.rs2;
  assign rd_e       = pkt_q.rd;
  assign opcode_e   = pkt_q.opcode;
  assign funct3_e   = pkt_q.funct3;
  assign funct7b5_e = pkt_q.funct7b5;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus hand-written
// hazard, stall, flush, reset and bypass (ID_WB_BYPASS_EN) sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_d;
  logic [31:0] instr_d, pc_d;
  logic        ready_d;
  logic [4:0]  a1, a2;
  logic [31:0] rd1, rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ready_e, flush_e;
  logic        valid_e;
  logic [31:0] pc_e, rs1_data_e, rs2_data_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [6:0]  opcode_e;
  logic [2:0]  funct3_e;
  logic        funct7b5_e;

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign rd1 = rf[a1];
  assign rd2 = rf[a2];

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .ready_d(ready_d), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ready_e(ready_e), .flush_e(flush_e), .valid_e(valid_e), .pc_e(pc_e),
    .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .opcode_e(opcode_e),
    .funct3_e(funct3_e), .funct7b5_e(funct7b5_e)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
  } vec_t;

  exp_t sb [$];
  exp_t last;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic exp_t act();
    exp_t a;
    a.v = valid_e;  a.pc = pc_e;  a.rs1d = rs1_data_e;  a.rs2d = rs2_data_e;
    a.imm = imm_e;  a.rs1 = rs1_e; a.rs2 = rs2_e; a.rd = rd_e;
    a.op = opcode_e; a.f3 = funct3_e; a.f7 = funct7b5_e;
    return a;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] imm);
    exp_t e;
    e.v    = 1'b1;
    e.pc   = pc;
    e.rs1  = ins[19:15];
    e.rs2  = ins[24:20];
    e.rd   = ins[11:7];
    e.op   = ins[6:0];
    e.f3   = ins[14:12];
    e.f7   = ins[30];
    e.imm  = imm;
    e.rs1d = (e.rs1 == 5'd0) ? 32'd0 : rf[e.rs1];
    e.rs2d = (e.rs2 == 5'd0) ? 32'd0 : rf[e.rs2];
    return e;
  endfunction

  task automatic chk(input string nm, input exp_t a, input exp_t e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic pop_chk(input string nm);
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s: scoreboard empty, got valid_e=%b want entry", nm, valid_e);
    end else begin
      last = sb.pop_front();
      chk(nm, act(), last);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic re, input logic fl);
    valid_d = v; instr_d = ins; pc_d = pc; ready_e = re; flush_e = fl;
  endtask

  vec_t vt [13];

  initial begin
    exp_t zero;
    exp_t held;
    zero = '0;
    rst_n = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 | (i * 17);
    rf[0] = 32'hBAD0_0000;  // must never reach E

    vt[0]  = '{32'hFFF00293, 32'hFFFFFFFF};  // addi x5,x0,-1
    vt[1]  = '{32'h7FF08093, 32'h000007FF};  // addi x1,x1,2047
    vt[2]  = '{32'h0020A423, 32'h00000008};  // sw x2,8(x1)
    vt[3]  = '{32'hFE20AE23, 32'hFFFFFFFC};  // sw x2,-4(x1)
    vt[4]  = '{32'hFE208CE3, 32'hFFFFFFF8};  // beq x1,x2,-8
    vt[5]  = '{32'h0000A303, 32'h00000000};  // lw x6,0(x1)
    vt[6]  = '{32'h12345537, 32'h12345000};  // lui x10,0x12345
    vt[7]  = '{32'h001000EF, 32'h00000800};  // jal x1,2048
    vt[8]  = '{32'hFFDFF06F, 32'hFFFFFFFC};  // jal x0,-4
    vt[9]  = '{32'h002303B3, 32'h00000000};  // add x7,x6,x2
    vt[10] = '{32'h402303B3, 32'h00000000};  // sub x7,x6,x2
    vt[11] = '{32'hFFFFF197, 32'hFFFFF000};  // auipc x3,0xFFFFF
    vt[12] = '{32'h800280E7, 32'hFFFFF800};  // jalr x1,-2048(x5)

    #12;
    chk("reset_state", act(), zero);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(1'b1, vt[i].instr, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
      #1;
      chkv("vec_ready_d", {31'd0, ready_d}, 32'd1);
      chkv("vec_a1a2", {22'd0, a1, a2}, {22'd0, vt[i].instr[19:15], vt[i].instr[24:20]});
      sb.push_back(mk_exp(vt[i].instr, pc_d, vt[i].imm));
      @(posedge clk); #1;
      pop_chk("vec_out");
    end

    // load-use: lw x6 in E, add x7,x6,x2 in D
    @(negedge clk); drive(1'b1, 32'h0000A303, 32'h200, 1'b1, 1'b0);
    sb.push_back(mk_exp(instr_d, pc_d, 32'd0));
    @(posedge clk); #1; pop_chk("lu_load");
    @(negedge clk); drive(1'b1, 32'h002303B3, 32'h204, 1'b1, 1'b0);
    #1 chkv("lu_ready_d", {31'd0, ready_d}, 32'd0);
    @(posedge clk); #1; chkv("lu_bubble", {31'd0, valid_e}, 32'd0);
    @(negedge clk); #1 chkv("lu_ready_d2", {31'd0, ready_d}, 32'd1);
    sb.push_back(mk_exp(instr_d, pc_d, 32'd0));
    @(posedge clk); #1; pop_chk("lu_issue");

    // load to x0 never interlocks
    @(negedge clk); drive(1'b1, 32'h0000A003, 32'h208, 1'b1, 1'b0);
    sb.push_back(mk_exp(instr_d, pc_d, 32'd0));
    @(posedge clk); #1; pop_chk("lu_x0_load");
    @(negedge clk); drive(1'b1, 32'h002003B3, 32'h20C, 1'b1, 1'b0);
    #1 chkv("lu_x0_ready_d", {31'd0, ready_d}, 32'd1);
    sb.push_back(mk_exp(instr_d, pc_d, 32'd0));
    @(posedge clk); #1; pop_chk("lu_x0_issue");

    // 3-cycle stall
    @(negedge clk); drive(1'b1, 32'hFFF00293, 32'h300, 1'b1, 1'b0);
    sb.push_back(mk_exp(instr_d, pc_d, 32'hFFFFFFFF));
    @(posedge clk); #1; pop_chk("stall_load");
    held = last;
    @(negedge clk); drive(1'b1, 32'h402303B3, 32'h304, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1 chkv("stall_ready_d", {31'd0, ready_d}, 32'd0);
      @(posedge clk); #1; chk("stall_hold", act(), held);
      @(negedge clk);
    end
    ready_e = 1'b1;
    #1 chkv("stall_release_ready_d", {31'd0, ready_d}, 32'd1);
    sb.push_back(mk_exp(instr_d, pc_d, 32'd0));
    @(posedge clk); #1; pop_chk("stall_release");

    // flush while execute stalls; decode instruction dropped
    @(negedge clk); drive(1'b1, 32'h001000EF, 32'h400, 1'b0, 1'b1);
    #1 chkv("flush_ready_d", {31'd0, ready_d}, 32'd1);
    @(posedge clk); #1; chkv("flush_valid_e", {31'd0, valid_e}, 32'd0);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1; chkv("flush_dropped", {31'd0, valid_e}, 32'd0);

    // reset during a stall
    @(negedge clk); drive(1'b1, 32'h7FF08093, 32'h500, 1'b1, 1'b0);
    sb.push_back(mk_exp(instr_d, pc_d, 32'h7FF));
    @(posedge clk); #1; pop_chk("rst_pre");
    @(negedge clk); drive(1'b1, 32'h12345537, 32'h504, 1'b0, 1'b0);
    @(posedge clk); #3; rst_n = 1'b0;
    #1 chk("rst_async", act(), zero);
    @(negedge clk); rst_n = 1'b1; ready_e = 1'b1;
    sb.push_back(mk_exp(instr_d, pc_d, 32'h12345000));
    @(posedge clk); #1; pop_chk("rst_first_issue");

    // writeback bypass; without the macro rf data passes unmodified
    rf[3] = 32'd0;
    @(negedge clk); drive(1'b1, 32'h00018213, 32'h600, 1'b1, 1'b0);  // addi x4,x3,0
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    last = mk_exp(instr_d, pc_d, 32'd0);
`ifdef ID_WB_BYPASS_EN
    last.rs1d = 32'hDEADBEEF;
`endif
    sb.push_back(last);
    @(posedge clk); #1; pop_chk("byp_rs1");
    @(negedge clk); wb_rd = 5'd0; pc_d = 32'h604;
    sb.push_back(mk_exp(instr_d, pc_d, 32'd0));
    @(posedge clk); #1; pop_chk("byp_rd_x0");
    @(negedge clk); drive(1'b1, 32'h003303B3, 32'h608, 1'b1, 1'b0);  // add x7,x6,x3
    wb_rd = 5'd3; wb_data = 32'hCAFEF00D;
    last = mk_exp(instr_d, pc_d, 32'd0);
`ifdef ID_WB_BYPASS_EN
    last.rs2d = 32'hCAFEF00D;
`endif
    sb.push_back(last);
    @(posedge clk); #1; pop_chk("byp_rs2");

    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); wb_we = 1'b0;
    @(posedge clk); #1; chkv("idle", {31'd0, valid_e}, 32'd0);
    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL sb_drain: got %0d leftover want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
